// File: rtl/fp_align_serial_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_align_serial_if
// Description : Handshake and data bundle for the FP32 alignment/add stage.
//               The slave modport is the stage itself; the master modport is
//               whatever feeds operands in and takes results out.
//   inValid/inReady/opA/opB        operand-side valid/ready handshake
//   outValid/outReady              result-side valid/ready handshake
//   alignedResult/exponentOut/
//   alignedSign/guard/round/sticky unnormalized result for normalize
//   specialOut                     NaN/Inf input or exponent overflow
//   busy                           stage is not idle
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_align_serial_if;
  logic        inValid;
  logic        inReady;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        outValid;
  logic        outReady;
  logic [23:0] alignedResult;
  logic [7:0]  exponentOut;
  logic        alignedSign;
  logic        guardBit;
  logic        roundBit;
  logic        stickyBit;
  logic        specialOut;
  logic        busy;

  modport slave (
    input  inValid, opA, opB, outReady,
    output inReady, outValid, alignedResult, exponentOut, alignedSign,
           guardBit, roundBit, stickyBit, specialOut, busy
  );

  modport master (
    output inValid, opA, opB, outReady,
    input  inReady, outValid, alignedResult, exponentOut, alignedSign,
           guardBit, roundBit, stickyBit, specialOut, busy
  );
endinterface
`default_nettype wire

// File: rtl/fp_align_serial.sv
`default_nettype none
// ============================================================================
// Module      : fp_align_serial
// Description : Multi-cycle FP32 alignment/add stage feeding normalize.
//               Orders the operands by magnitude, shifts the smaller
//               mantissa right SHIFT_STEP bits per cycle while collecting
//               guard/round/sticky, then adds or subtracts.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, aborts any operation
//   bus    : slave side of fp_align_serial_if (operand and result handshakes)
// Revision    : 1.0 - initial release
// ============================================================================
module fp_align_serial #(
  parameter int SHIFT_STEP = 1,   // 1, 2 or 4
  parameter int MAX_SHIFT  = 27   // 24 mantissa + G + R + S
) (
  input  wire logic       clk,
  input  wire logic       reset,
  fp_align_serial_if.slave bus
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COMPARE = 3'd1;
  localparam logic [2:0] S_SHIFT   = 3'd2;
  localparam logic [2:0] S_ADD     = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [4:0] STEP_C      = 5'(SHIFT_STEP);
  localparam logic [4:0] MAX_SHIFT_C = 5'(MAX_SHIFT);

  logic [2:0]  state_q, state_d;

  logic [31:0] opA_q, opB_q;
  logic [26:0] extL_q, extS_q;     // {mant24, G, R, S}
  logic [7:0]  expL_q;             // effective exponent of the larger operand
  logic        signL_q;
  logic        sameSign_q;
  logic [4:0]  rem_q;              // alignment positions still to shift

  logic [23:0] result_q;
  logic [7:0]  expOut_q;
  logic        sign_q;
  logic        guard_q, round_q, sticky_q;
  logic        special_q;

  // ---------------------------------------------------------------- compare
  logic        aIsLarger;
  logic [31:0] opL, opS;
  logic [7:0]  expLEff, expSEff, expDiff;
  logic [4:0]  shiftClamp;
  logic        cmpSpecial;

  // Ties choose A; {exp,frac} ordering also guarantees expL >= expS.
  assign aIsLarger  = (opA_q[30:0] >= opB_q[30:0]);
  assign opL        = aIsLarger ? opA_q : opB_q;
  assign opS        = aIsLarger ? opB_q : opA_q;
  // Denormals sit at the same scale as exponent 1.
  assign expLEff    = (opL[30:23] == 8'd0) ? 8'd1 : opL[30:23];
  assign expSEff    = (opS[30:23] == 8'd0) ? 8'd1 : opS[30:23];
  assign expDiff    = expLEff - expSEff;
  assign shiftClamp = (expDiff > {3'd0, MAX_SHIFT_C}) ? MAX_SHIFT_C : expDiff[4:0];
  assign cmpSpecial = (&opA_q[30:23]) | (&opB_q[30:23]);

  // ------------------------------------------------------------------ shift
  logic [4:0]  shAmt;
  logic [4:0]  remNext;
  logic [26:0] lostMask;
  logic [26:0] extShifted;

  assign shAmt      = (rem_q < STEP_C) ? rem_q : STEP_C;
  assign remNext    = rem_q - shAmt;
  assign lostMask   = (27'd1 << shAmt) - 27'd1;
  // Everything that drops below bit 0 is folded into the sticky position.
  assign extShifted = (extS_q >> shAmt) | {26'd0, |(extS_q & lostMask)};

  // -------------------------------------------------------------------- add
  logic [27:0] sumRaw;
  logic        carry;
  logic [26:0] sumAdj;
  logic [8:0]  expAdj;
  logic        sumZero;

  assign sumRaw  = sameSign_q ? ({1'b0, extL_q} + {1'b0, extS_q})
                              : ({1'b0, extL_q} - {1'b0, extS_q});
  assign carry   = sumRaw[27];
  assign sumAdj  = carry ? {sumRaw[27:2], sumRaw[1] | sumRaw[0]} : sumRaw[26:0];
  assign expAdj  = {1'b0, expL_q} + {8'd0, carry};
  assign sumZero = (sumAdj == 27'd0);

  // ---------------------------------------------------------- state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // ------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (bus.inValid) state_d = S_COMPARE;
      S_COMPARE: begin
        if (cmpSpecial)               state_d = S_DONE;
        else if (shiftClamp == 5'd0)  state_d = S_ADD;
        else                          state_d = S_SHIFT;
      end
      S_SHIFT:   if (remNext == 5'd0) state_d = S_ADD;
      S_ADD:     state_d = S_DONE;
      S_DONE:    if (bus.outReady) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    bus.inReady  = 1'b0;
    bus.outValid = 1'b0;
    bus.busy     = 1'b1;
    case (state_q)
      S_IDLE: begin
        bus.inReady = 1'b1;
        bus.busy    = 1'b0;
      end
      S_DONE:  bus.outValid = 1'b1;
      default: ;
    endcase
  end

  assign bus.alignedResult = result_q;
  assign bus.exponentOut   = expOut_q;
  assign bus.alignedSign   = sign_q;
  assign bus.guardBit      = guard_q;
  assign bus.roundBit      = round_q;
  assign bus.stickyBit     = sticky_q;
  assign bus.specialOut    = special_q;

  // --------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (reset) begin
      opA_q      <= 32'd0;
      opB_q      <= 32'd0;
      extL_q     <= 27'd0;
      extS_q     <= 27'd0;
      expL_q     <= 8'd0;
      signL_q    <= 1'b0;
      sameSign_q <= 1'b0;
      rem_q      <= 5'd0;
      result_q   <= 24'd0;
      expOut_q   <= 8'd0;
      sign_q     <= 1'b0;
      guard_q    <= 1'b0;
      round_q    <= 1'b0;
      sticky_q   <= 1'b0;
      special_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.inValid) begin
            opA_q <= bus.opA;
            opB_q <= bus.opB;
          end
        end
        S_COMPARE: begin
          extL_q     <= {|opL[30:23], opL[22:0], 3'b000};
          extS_q     <= {|opS[30:23], opS[22:0], 3'b000};
          expL_q     <= expLEff;
          signL_q    <= opL[31];
          sameSign_q <= (opL[31] == opS[31]);
          rem_q      <= shiftClamp;
          if (cmpSpecial) begin
            result_q  <= 24'd0;
            expOut_q  <= 8'd0;
            sign_q    <= 1'b0;
            guard_q   <= 1'b0;
            round_q   <= 1'b0;
            sticky_q  <= 1'b0;
            special_q <= 1'b1;
          end
        end
        S_SHIFT: begin
          extS_q <= extShifted;
          rem_q  <= remNext;
        end
        S_ADD: begin
          result_q  <= sumAdj[26:3];
          guard_q   <= sumAdj[2];
          round_q   <= sumAdj[1];
          sticky_q  <= sumAdj[0];
          // Exact cancellation is reported as +0 with a zero exponent.
          expOut_q  <= sumZero ? 8'd0 : expAdj[7:0];
          sign_q    <= sumZero ? 1'b0 : signL_q;
          special_q <= (expAdj == 9'd255);
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/fp_align_serial.md
Name: fp_align_serial

Overview:
Multi-cycle alignment/add stage of the FP32 adder, placed directly upstream of the normalize stage.
- Unpacks two IEEE-754 single-precision operands and orders them by magnitude.
- Right-shifts the smaller mantissa serially, capturing guard/round/sticky bits.
- Adds or subtracts the mantissas.
- Presents the unnormalized 24-bit result, exponent, sign and G/R/S to normalize, using a valid/ready handshake on both sides.

Parameters:
SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4.
MAX_SHIFT, 27, alignment shift clamp: 24 mantissa + G + R + S positions.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
inValid  in  1  operand pair valid
inReady  out  1  block can accept operands; high only in IDLE
opA  in  32  operand A, IEEE-754 single
opB  in  32  operand B, IEEE-754 single
outValid  out  1  result valid
outReady  in  1  downstream accepts result
alignedResult  out  24  unnormalized mantissa result, implicit bit at [23]
exponentOut  out  8  exponent of alignedResult
alignedSign  out  1  result sign
guardBit  out  1  first bit below alignedResult LSB
roundBit  out  1  second bit below LSB
stickyBit  out  1  OR of all lower discarded bits
specialOut  out  1  NaN/Inf input or exponent overflow; other data outputs are don't-care
busy  out  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high, on clk rising edge. On reset: state=IDLE; all outputs 0 except inReady=1. Reset in any state aborts the operation with no output.
- States: IDLE -> COMPARE -> SHIFT -> ADD -> DONE -> IDLE.
- IDLE:
  - inReady=1.
  - Capture opA/opB on inValid && inReady.
- COMPARE (1 cycle):
  - Implicit bit = (exp != 0). An exponent of 0 is treated as 1 for denormals.
  - Larger operand L = larger {exp, frac} magnitude; ties pick A. S = the other operand.
  - d = expL - expS, clamped to MAX_SHIFT.
  - Build 27-bit extended values {mant24, G, R, S}, initialised to {mant, 3'b0}.
  - Any exp==255 input: set specialOut=1 and go directly to DONE.
- SHIFT: ceil(d/SHIFT_STEP) cycles, zero cycles when d=0.
  - Each cycle shifts S's extended value right by min(SHIFT_STEP, remaining).
  - Bit0 (sticky) = OR of old bit0 and every bit shifted past it.
  - Remaining-count decrements to 0, then go to ADD.
- ADD (1 cycle):
  - Same signs: 28-bit sum = extL + extS.
  - Different signs: extL - extS. This never goes negative because of the ordering.
  - Carry set (bit 27): shift the sum right 1 with sticky OR-folding and increment the exponent. If the incremented exponent = 255, set specialOut=1.
  - alignedResult = sum[26:3]; guardBit = [2]; roundBit = [1]; stickyBit = [0].
  - exponentOut = expL, or expL+1 on carry. An expL of 0 is reported as 1.
  - alignedSign = sign(L). An exact zero result forces sign 0 and exponentOut 0.
- DONE:
  - outValid=1. All data outputs registered and held stable while outValid && !outReady.
  - On outReady, go to IDLE: outValid falls and inReady rises the next cycle.
- Latency (acceptance edge to outValid high) = 3 + ceil(d/SHIFT_STEP) cycles; special inputs = 2 cycles. Throughput is one operation at a time with no overlap.
- inValid is ignored outside IDLE; opA/opB may change freely after acceptance.
- Output regs update only on the ADD->DONE or COMPARE->DONE transition.

Test Plan:
1. 0x3F800000 + 0x3F800000 (1+1), outReady=1 -> outValid 3 cycles after accept; alignedResult=0x800000, exponentOut=0x80, sign=0, G/R/S=000.
2. 0x3F800000 + 0x33800000 (d=24), SHIFT_STEP=1 -> 24 SHIFT cycles, outValid at cycle 27; alignedResult=0x800000, exponentOut=0x7F, G=1, R=0, S=0. Repeat with SHIFT_STEP=4 -> outValid at cycle 9, same data.
3. 0x3F800000 + 0xBF800000 -> alignedResult=0, exponentOut=0, alignedSign=0, G/R/S=000.
4. 0x3F800000 + 0x2F800000 (d=32, clamped to 27) -> 27 shift cycles; alignedResult=0x800000, exponentOut=0x7F, G=0, R=0, S=1.
5. Backpressure: hold outReady=0 for 5 cycles after outValid -> outputs constant, inReady=0, busy=1. Separately, assert reset during SHIFT -> next cycle state IDLE, outValid=0, inReady=1.
6. opA=0x7FC00000 (NaN) + 0x3F800000 -> specialOut=1, outValid 2 cycles after accept. Separately, 0x7F7FFFFF + 0x7F7FFFFF -> carry, exponentOut=0xFF, specialOut=1.
